fpu_core: RTL and testbench



---
 rtl/fpu_core.sv | 267 ++++++++++++++++++++++++++
 tb/tb_fpu_core.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_core.sv
// fpu_core: memory-mapped IEEE-754 single-precision add/sub coprocessor on an 8-bit host bus.
// Optional read-only status register at 0xD, enabled by defining FPU_STATUS_REG_EN.
`timescale 1ns/1ps

package fpu_core_pkg;
   typedef enum logic [7:0] {
      op_add = 8'h00,
      op_sub = 8'h01
   } e_fpu_operation;
endpackage

module fpu_core
   import fpu_core_pkg::*;
(
   input  logic       clk,
   input  logic       arst,
   input  logic [7:0] databus_in,
   output logic [7:0] databus_out,
   input  logic [3:0] addr,
   input  logic       cs,
   input  logic       rd,
   input  logic       wr,
   input  logic       end_ack,
   output logic       cmd_end,
   output logic       busy
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // DECODE is the extra pipeline slot that gives the fixed six-cycle busy window.
   typedef enum logic [2:0] {
      ST_IDLE, ST_DECODE, ST_UNPACK, ST_ALIGN, ST_ADD, ST_NORMALIZE, ST_ROUND, ST_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] op_a, op_b, result;
   logic [7:0]  cmd_reg;
   logic        wr_q;
   logic        bus_wr, cmd_start;

   assign bus_wr    = ~cs & ~wr;
   assign cmd_start = bus_wr & wr_q & (addr == 4'h8) & (state == ST_IDLE);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         op_a    <= '0;
         op_b    <= '0;
         cmd_reg <= '0;
         wr_q    <= '0;
      end else begin
         wr_q <= wr;
         if (bus_wr && !busy) begin
            case (addr)
               4'h0:    op_a[7:0]   <= databus_in;
               4'h1:    op_a[15:8]  <= databus_in;
               4'h2:    op_a[23:16] <= databus_in;
               4'h3:    op_a[31:24] <= databus_in;
               4'h4:    op_b[7:0]   <= databus_in;
               4'h5:    op_b[15:8]  <= databus_in;
               4'h6:    op_b[23:16] <= databus_in;
               4'h7:    op_b[31:24] <= databus_in;
               default: ;
            endcase
         end
         if (cmd_start) cmd_reg <= databus_in;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      if (cmd_start) state_nxt = ST_DECODE;
         ST_DECODE:    state_nxt = ST_UNPACK;
         ST_UNPACK:    state_nxt = ST_ALIGN;
         ST_ALIGN:     state_nxt = ST_ADD;
         ST_ADD:       state_nxt = ST_NORMALIZE;
         ST_NORMALIZE: state_nxt = ST_ROUND;
         ST_ROUND:     state_nxt = ST_DONE;
         ST_DONE:      if (end_ack) state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      cmd_end = 1'b0;
      case (state)
         ST_IDLE: ;
         ST_DONE: cmd_end = 1'b1;
         default: busy = 1'b1;
      endcase
   end

   // Stage registers
   logic        d_special, d_sa, d_sb;
   logic [31:0] d_special_val;
   logic [7:0]  d_ea, d_eb;
   logic [23:0] d_ma, d_mb;
   logic        u_sign, u_eff_sub;
   logic [7:0]  u_el, u_diff;
   logic [23:0] u_ml, u_ms;
   logic [26:0] a_ml, a_ms;
   logic [27:0] s_sum;
   logic [26:0] n_frac;
   logic [9:0]  n_exp;
   logic        n_zero;

   // Decode: special operands and effective sign of B
   logic        dc_sb, dc_nan_a, dc_nan_b, dc_inf_a, dc_inf_b, dc_known, dc_special;
   logic [31:0] dc_special_val;

   always_comb begin
      dc_sb          = op_b[31] ^ (cmd_reg == op_sub);
      dc_nan_a       = (&op_a[30:23]) & (|op_a[22:0]);
      dc_nan_b       = (&op_b[30:23]) & (|op_b[22:0]);
      dc_inf_a       = (&op_a[30:23]) & ~(|op_a[22:0]);
      dc_inf_b       = (&op_b[30:23]) & ~(|op_b[22:0]);
      dc_known       = (cmd_reg == op_add) || (cmd_reg == op_sub);
      dc_special     = 1'b1;
      dc_special_val = QNAN;
      if (!dc_known || dc_nan_a || dc_nan_b) begin
         dc_special_val = QNAN;
      end else if (dc_inf_a && dc_inf_b) begin
         dc_special_val = (op_a[31] != dc_sb) ? QNAN : {op_a[31], 8'hFF, 23'h0};
      end else if (dc_inf_a) begin
         dc_special_val = {op_a[31], 8'hFF, 23'h0};
      end else if (dc_inf_b) begin
         dc_special_val = {dc_sb, 8'hFF, 23'h0};
      end else begin
         dc_special = 1'b0;
      end
   end

   logic        a_ge_b;
   logic [49:0] al_wide;
   logic [26:0] al_ms;
   logic [27:0] ad_sum;

   assign a_ge_b = {d_ea, d_ma} >= {d_eb, d_mb};

   // Alignment keeps 24 significand bits plus guard, round and a sticky OR of the rest.
   always_comb begin
      al_wide = {u_ms, 26'h0} >> u_diff;
      if (u_diff > 8'd26) al_ms = {26'h0, |u_ms};
      else                al_ms = {al_wide[49:24], |al_wide[23:0]};
   end

   assign ad_sum = u_eff_sub ? ({1'b0, a_ml} - {1'b0, a_ms}) : ({1'b0, a_ml} + {1'b0, a_ms});

   logic [4:0]  nm_lz;
   logic [26:0] nm_frac;
   logic [9:0]  nm_exp;

   always_comb begin
      nm_lz = '0;
      for (int unsigned i = 0; i < 27; i++)
         if (s_sum[i]) nm_lz = 5'(26 - i);
      if (s_sum[27]) begin
         nm_frac = {s_sum[27:2], |s_sum[1:0]};
         nm_exp  = {2'b00, u_el} + 10'd1;
      end else begin
         nm_frac = s_sum[26:0] << nm_lz;
         nm_exp  = {2'b00, u_el} - {5'b0, nm_lz};
      end
   end

   logic        rn_up, rn_uflow, rn_oflow;
   logic [24:0] rn_mant;
   logic [9:0]  rn_exp;
   logic [22:0] rn_frac;
   logic [31:0] rn_result;

   always_comb begin
      rn_up    = n_frac[2] & (n_frac[3] | n_frac[1] | n_frac[0]);
      rn_mant  = {1'b0, n_frac[26:3]} + {24'h0, rn_up};
      rn_exp   = n_exp + {9'h0, rn_mant[24]};
      rn_frac  = rn_mant[24] ? rn_mant[23:1] : rn_mant[22:0];
      rn_uflow = rn_exp[9] || (rn_exp == '0);
      rn_oflow = !rn_exp[9] && (rn_exp >= 10'd255);
      if (d_special)     rn_result = d_special_val;
      else if (n_zero)   rn_result = '0;
      else if (rn_uflow) rn_result = {u_sign, 31'h0};
      else if (rn_oflow) rn_result = {u_sign, 8'hFF, 23'h0};
      else               rn_result = {u_sign, rn_exp[7:0], rn_frac};
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         d_special <= '0; d_special_val <= '0; d_sa <= '0; d_sb <= '0;
         d_ea <= '0; d_eb <= '0; d_ma <= '0; d_mb <= '0;
         u_sign <= '0; u_eff_sub <= '0; u_el <= '0; u_diff <= '0; u_ml <= '0; u_ms <= '0;
         a_ml <= '0; a_ms <= '0; s_sum <= '0;
         n_frac <= '0; n_exp <= '0; n_zero <= '0;
         result <= '0;
      end else begin
         case (state)
            ST_DECODE: begin
               d_special     <= dc_special;
               d_special_val <= dc_special_val;
               d_sa          <= op_a[31];
               d_sb          <= dc_sb;
               d_ea          <= op_a[30:23];
               d_eb          <= op_b[30:23];
               d_ma          <= (op_a[30:23] == '0) ? '0 : {1'b1, op_a[22:0]};
               d_mb          <= (op_b[30:23] == '0) ? '0 : {1'b1, op_b[22:0]};
            end
            ST_UNPACK: begin
               u_eff_sub <= d_sa ^ d_sb;
               if (a_ge_b) begin
                  u_sign <= d_sa; u_el <= d_ea; u_ml <= d_ma; u_ms <= d_mb; u_diff <= d_ea - d_eb;
               end else begin
                  u_sign <= d_sb; u_el <= d_eb; u_ml <= d_mb; u_ms <= d_ma; u_diff <= d_eb - d_ea;
               end
            end
            ST_ALIGN: begin
               a_ml <= {u_ml, 3'b000};
               a_ms <= al_ms;
            end
            ST_ADD:       s_sum <= ad_sum;
            ST_NORMALIZE: begin
               n_frac <= nm_frac;
               n_exp  <= nm_exp;
               n_zero <= (s_sum == '0);
            end
            ST_ROUND:     result <= rn_result;
            default: ;
         endcase
      end
   end

`ifdef FPU_STATUS_REG_EN
   logic [3:0] status_q;  // {invalid, overflow, sign, zero}

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         status_q <= '0;
      end else if (state == ST_ROUND) begin
         status_q <= {(&rn_result[30:23]) & (|rn_result[22:0]),
                      rn_result[30:0] == 31'h7F80_0000,
                      rn_result[31],
                      rn_result[30:0] == '0};
      end
   end
`endif

   always_comb begin
      databus_out = '0;
      if (!cs && !rd) begin
         case (addr)
            4'h9:    databus_out = result[7:0];
            4'hA:    databus_out = result[15:8];
            4'hB:    databus_out = result[23:16];
            4'hC:    databus_out = result[31:24];
`ifdef FPU_STATUS_REG_EN
            4'hD:    databus_out = {2'b00, status_q, cmd_end, busy};
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_core.sv
// tb_fpu_core: stimulus queues hand-computed results; a monitor reads the result
// bytes whenever cmd_end rises and checks them with the busy window length.
`timescale 1ns/1ps

module tb_fpu_core;
   import fpu_core_pkg::*;

   logic       clk = 1'b0;
   logic       arst, end_ack, cs, rd, wr, cmd_end, busy;
   logic [7:0] databus_in, databus_out;
   logic [3:0] addr;

   logic       h_cs, h_rd, h_wr, m_active;
   logic [3:0] h_addr, m_addr;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          resp_cnt = 0;
   logic [31:0] exp_q[$];

   assign cs   = m_active ? 1'b0 : h_cs;
   assign rd   = m_active ? 1'b0 : h_rd;
   assign wr   = m_active ? 1'b1 : h_wr;
   assign addr = m_active ? m_addr : h_addr;

   always #5 clk = ~clk;

   fpu_core dut (
      .clk(clk), .arst(arst), .databus_in(databus_in), .databus_out(databus_out),
      .addr(addr), .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack),
      .cmd_end(cmd_end), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   // Monitor: owns the bus while it reads the four result bytes.
   initial begin
      int          busy_cnt;
      logic        ce_prev;
      logic [31:0] got;
      busy_cnt = 0;
      ce_prev  = 1'b0;
      m_active = 1'b0;
      m_addr   = '0;
      forever begin
         @(negedge clk);
         if (busy) busy_cnt++;
         else if (!cmd_end) busy_cnt = 0;
         if (cmd_end && !ce_prev) begin
            m_active = 1'b1;
            for (int i = 0; i < 4; i++) begin
               m_addr = 4'(9 + i);
               #1;
               got[8*i +: 8] = databus_out;
            end
            m_active = 1'b0;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_cmd_end: actual result %h required no cmd_end", got);
            end else begin
               chk("result", got, exp_q.pop_front());
               chk("busy_cycles", 32'(busy_cnt), 32'd6);
            end
            busy_cnt = 0;
            resp_cnt++;
         end
         ce_prev = cmd_end;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: actual still running required finished");
      $fatal(1);
   end

   task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
      h_addr = a; databus_in = d; h_cs = 1'b0; h_wr = 1'b0;
      @(negedge clk);
      h_cs = 1'b1; h_wr = 1'b1;
      @(negedge clk);
   endtask

   task automatic bus_read32(output logic [31:0] v);
      for (int i = 0; i < 4; i++) begin
         h_addr = 4'(9 + i); h_cs = 1'b0; h_rd = 1'b0;
         #1;
         v[8*i +: 8] = databus_out;
      end
      h_cs = 1'b1; h_rd = 1'b1;
   endtask

   task automatic load_operands(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 4; i++) bus_write(4'(i), a[8*i +: 8]);
      for (int i = 0; i < 4; i++) bus_write(4'(4 + i), b[8*i +: 8]);
   endtask

   task automatic start_cmd(input logic [7:0] op, input logic [31:0] res);
      exp_q.push_back(res);
      bus_write(4'h8, op);
   endtask

   task automatic wait_done();
      int start;
      int k;
      start = resp_cnt;
      k = 0;
      while (resp_cnt == start && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("cmd_end_seen", 32'(resp_cnt - start), 32'd1);
   endtask

   task automatic ack();
      end_ack = 1'b1;
      @(negedge clk);
      end_ack = 1'b0;
      chk("cmd_end_after_ack", {31'h0, cmd_end}, 32'd0);
      chk("busy_after_ack", {31'h0, busy}, 32'd0);
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                      input logic [31:0] res);
      load_operands(a, b);
      start_cmd(op, res);
      wait_done();
      ack();
   endtask

   logic [31:0] va [12] = '{32'h43A9AB64, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000,
                            32'h3F800000, 32'h3F800000, 32'h00800000, 32'hFF800000,
                            32'h7FC00001, 32'h00000001, 32'h3F800000, 32'h40000000};
   logic [31:0] vb [12] = '{32'hC479FFF0, 32'h7F7FFFFF, 32'h7F800000, 32'h33800000,
                            32'h33800001, 32'h33800000, 32'h00800001, 32'h3F800000,
                            32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000};
   logic [7:0]  vop [12] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01,
                             8'h01, 8'h00, 8'h00, 8'h00, 8'h05, 8'h01};
   // Exact difference for the first entry is 0xA52A3E * 2^-14, so no rounding applies.
   logic [31:0] vres [12] = '{32'hC4252A3E, 32'h7F800000, 32'h7FC00000, 32'h3F800000,
                              32'h3F800001, 32'h3F7FFFFF, 32'h80000000, 32'hFF800000,
                              32'h7FC00000, 32'h3F800000, 32'h7FC00000, 32'h40400000};

   initial begin
      logic [31:0] r;
      arst = 1'b1; end_ack = 1'b0; databus_in = '0;
      h_cs = 1'b1; h_rd = 1'b1; h_wr = 1'b1; h_addr = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", {31'h0, busy}, 32'd0);
      chk("reset_cmd_end", {31'h0, cmd_end}, 32'd0);
      chk("reset_databus_out", {24'h0, databus_out}, 32'd0);
      bus_read32(r);
      chk("reset_result", r, 32'd0);
      @(negedge clk);
      arst = 1'b0;
      repeat (2) @(negedge clk);

      end_ack = 1'b1;
      @(negedge clk);
      end_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack_busy", {31'h0, busy}, 32'd0);
      chk("idle_ack_cmd_end", {31'h0, cmd_end}, 32'd0);

      load_operands(32'h43A9AB64, 32'h43A9AB64);
      start_cmd(op_add, 32'h4429AB64);
      wait_done();
      repeat (3) @(negedge clk);
      chk("cmd_end_held", {31'h0, cmd_end}, 32'd1);
      ack();

      start_cmd(op_sub, 32'h00000000);
      wait_done();
      ack();

      // Command and operand writes during busy must not disturb the running add.
      start_cmd(op_add, 32'h4429AB64);
      bus_write(4'h8, op_sub);
      bus_write(4'h0, 8'h00);
      wait_done();
      ack();
      start_cmd(op_add, 32'h4429AB64);
      wait_done();

      bus_write(4'h8, op_sub);
      chk("cmd_in_done_cmd_end", {31'h0, cmd_end}, 32'd1);
      chk("cmd_in_done_busy", {31'h0, busy}, 32'd0);
      ack();
      repeat (8) @(negedge clk);
      chk("no_restart_busy", {31'h0, busy}, 32'd0);
      bus_read32(r);
      chk("result_retained", r, 32'h4429AB64);
      @(negedge clk);

      for (int i = 0; i < 12; i++) run(va[i], vb[i], vop[i], vres[i]);

      load_operands(32'h43A9AB64, 32'hC479FFF0);
      bus_write(4'h8, op_add);
      arst = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_busy", {31'h0, busy}, 32'd0);
      chk("abort_cmd_end", {31'h0, cmd_end}, 32'd0);
      bus_read32(r);
      chk("abort_result", r, 32'd0);
      @(negedge clk);
      arst = 1'b0;
      repeat (2) @(negedge clk);
      run(32'h3F800000, 32'h3F800000, op_add, 32'h40000000);

      repeat (10) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
